// File: rtl/scaled_tick_pkg.sv
// Shared types and defaults for the multi-channel clock-enable generator.
package scaled_tick_pkg;

  localparam int unsigned DEFAULT_CNT_W = 28;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } tick_mode_t;

endpackage

// File: rtl/scaled_tick_channel.sv
// One divider channel: counter, shadow/active divisor pair, tick pulse, square wave and one-shot flag.
module scaled_tick_channel
  import scaled_tick_pkg::*;
#(
  parameter int unsigned CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned DEFAULT_DIV = 100_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  tick_mode_t       mode,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  input  logic             sync_clear,
  output logic             tick,
  output logic             sq,
  output logic             done
);

  localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] div_shadow, div_shadow_n;
  logic [CNT_W-1:0] div_act, div_act_n;
  logic             tick_n, sq_n, done_n;
  logic             enable_q;
  logic [CNT_W-1:0] last_c;
  logic             tc_c;

  // A divisor of 0 behaves like 1, so the terminal count is 0 in both cases.
  assign last_c = (div_act == '0) ? '0 : div_act - CNT_W'(1);
  assign tc_c   = enable && (cnt == last_c);

  // Next-state logic, priority: sync_clear, disabled, one-shot hold, count.
  always_comb begin
    cnt_n        = cnt;
    tick_n       = 1'b0;
    sq_n         = sq;
    done_n       = done;
    div_act_n    = div_act;
    div_shadow_n = div_load ? div_in : div_shadow;

    if (sync_clear) begin
      cnt_n  = '0;
      sq_n   = 1'b0;
      done_n = 1'b0;
    end else if (!enable) begin
      cnt_n     = '0;
      sq_n      = 1'b0;
      done_n    = 1'b0;
      div_act_n = div_shadow_n;
    end else if (done && enable_q) begin
      cnt_n = '0;
    end else if (tc_c) begin
      cnt_n     = '0;
      tick_n    = 1'b1;
      sq_n      = ~sq;
      div_act_n = div_shadow_n;
      if (mode == MODE_ONESHOT) begin
        done_n = 1'b1;
      end
    end else begin
      cnt_n = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      tick       <= 1'b0;
      sq         <= 1'b0;
      done       <= 1'b0;
      enable_q   <= 1'b0;
      div_shadow <= RESET_DIV;
      div_act    <= RESET_DIV;
    end else begin
      cnt        <= cnt_n;
      tick       <= tick_n;
      sq         <= sq_n;
      done       <= done_n;
      enable_q   <= enable;
      div_shadow <= div_shadow_n;
      div_act    <= div_act_n;
    end
  end

endmodule

// File: rtl/scaled_tick_gen.sv
// Multi-channel programmable clock-enable generator: one divider channel per enable bit.
module scaled_tick_gen
  import scaled_tick_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned DEFAULT_DIV = 100_000_000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*CNT_W-1:0] div_in,
  input  logic [CHANNELS-1:0]       div_load,
  input  logic                      sync_clear,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       sq,
  output logic [CHANNELS-1:0]       done
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    scaled_tick_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable[i]),
      .mode      (tick_mode_t'(mode[i])),
      .div_in    (div_in[i*CNT_W +: CNT_W]),
      .div_load  (div_load[i]),
      .sync_clear(sync_clear),
      .tick      (tick[i]),
      .sq        (sq[i]),
      .done      (done[i])
    );
  end

endmodule

// File: tb/tb_scaled_tick_gen.sv
// Self-checking bench for scaled_tick_gen: directed scenarios plus random traffic against a countdown model.
module tb_scaled_tick_gen;

  localparam int unsigned CH   = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned DDIV = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [CH-1:0]    enable = '0;
  logic [CH-1:0]    mode = '0;
  logic [CH*CW-1:0] div_in = '0;
  logic [CH-1:0]    div_load = '0;
  logic             sync_clear = 1'b0;
  logic [CH-1:0]    tick, sq, done;

  int checks = 0;
  int errors = 0;

  scaled_tick_gen #(
    .CHANNELS   (CH),
    .CNT_W      (CW),
    .DEFAULT_DIV(DDIV)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .div_in    (div_in),
    .div_load  (div_load),
    .sync_clear(sync_clear),
    .tick      (tick),
    .sq        (sq),
    .done      (done)
  );

  always #5 clock = ~clock;

  // Reference model: cycles remaining until the next tick, tick count parity for sq.
  int unsigned   m_rem[CH];
  int unsigned   m_act[CH];
  int unsigned   m_shadow[CH];
  int unsigned   m_ntick[CH];
  logic [CH-1:0] m_tick, m_sq, m_done;

  function automatic int unsigned eff(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < CH; i++) begin
      if (reset) begin
        m_act[i] = DDIV; m_shadow[i] = DDIV; m_rem[i] = eff(DDIV);
        m_ntick[i] = 0; m_done[i] = 1'b0; m_tick[i] = 1'b0;
      end else begin
        int unsigned nxt;
        nxt = div_load[i] ? int'(div_in[i*CW +: CW]) : m_shadow[i];
        m_tick[i] = 1'b0;
        if (sync_clear) begin
          m_rem[i] = eff(m_act[i]); m_ntick[i] = 0; m_done[i] = 1'b0;
        end else if (!enable[i]) begin
          m_act[i] = nxt; m_rem[i] = eff(nxt); m_ntick[i] = 0; m_done[i] = 1'b0;
        end else if (m_done[i]) begin
          m_tick[i] = 1'b0;
        end else if (m_rem[i] == 1) begin
          m_tick[i] = 1'b1; m_ntick[i]++; m_act[i] = nxt; m_rem[i] = eff(nxt);
          if (mode[i]) m_done[i] = 1'b1;
        end else begin
          m_rem[i]--;
        end
        m_shadow[i] = nxt;
      end
      m_sq[i] = m_ntick[i][0];
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({tick, sq, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs tick=%b sq=%b done=%b want all 0", tick, sq, done);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (tick !== m_tick || sq !== m_sq || done !== m_done) begin
        errors++;
        $display("FAIL reset_idle c=%0d tick=%b/%b sq=%b/%b done=%b/%b", c, tick, m_tick, sq, m_sq, done, m_done);
      end
    end
  endtask

  task automatic test_default_div();
    enable = 4'b0001;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      checks++;
      if (tick !== m_tick || sq !== m_sq || done !== m_done) begin
        errors++;
        $display("FAIL default_model c=%0d tick=%b/%b sq=%b/%b done=%b/%b", c, tick, m_tick, sq, m_sq, done, m_done);
      end
      checks++;
      if (tick !== {3'b000, (c % 5 == 0)}) begin
        errors++;
        $display("FAIL default_tick c=%0d got %b want %b", c, tick, {3'b000, (c % 5 == 0)});
      end
    end
    enable = '0;
    @(negedge clock);
  endtask

  task automatic test_div_update();
    div_in[1*CW +: CW] = CW'(4);
    div_load = 4'b0010;
    @(negedge clock);
    div_load = '0;
    enable = 4'b0010;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      checks++;
      if (tick !== m_tick || sq !== m_sq || done !== m_done) begin
        errors++;
        $display("FAIL update_model c=%0d tick=%b/%b sq=%b/%b done=%b/%b", c, tick, m_tick, sq, m_sq, done, m_done);
      end
      checks++;
      if (tick[1] !== (c == 4 || c == 11)) begin
        errors++;
        $display("FAIL update_tick c=%0d got %b want %b", c, tick[1], (c == 4 || c == 11));
      end
      div_load = '0;
      if (c == 2) begin
        div_in[1*CW +: CW] = CW'(7);
        div_load = 4'b0010;
      end
    end
  endtask

  task automatic test_bypass();
    int tc = -1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock);
      checks++;
      if (tick !== m_tick || sq !== m_sq || done !== m_done) begin
        errors++;
        $display("FAIL bypass_model c=%0d tick=%b/%b sq=%b/%b done=%b/%b", c, tick, m_tick, sq, m_sq, done, m_done);
      end
      if (tc > 0 && c > tc) begin
        checks++;
        if (tick[1] !== ((c - tc) % 3 == 0)) begin
          errors++;
          $display("FAIL bypass_tick c=%0d got %b want %b", c, tick[1], ((c - tc) % 3 == 0));
        end
      end
      div_load = '0;
      if (tc < 0 && m_rem[1] == 1) begin
        div_in[1*CW +: CW] = CW'(3);
        div_load = 4'b0010;
        tc = c + 1;
      end
    end
    checks++;
    if (tc < 0) begin
      errors++;
      $display("FAIL bypass_no_tc got none want a terminal count");
    end
    enable = '0;
    @(negedge clock);
  endtask

  task automatic test_oneshot();
    div_in[2*CW +: CW] = CW'(6);
    div_load = 4'b0100;
    mode = 4'b0100;
    @(negedge clock);
    div_load = '0;
    for (int pass = 0; pass < 2; pass++) begin
      enable = 4'b0100;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clock);
        checks++;
        if (tick !== m_tick || sq !== m_sq || done !== m_done) begin
          errors++;
          $display("FAIL oneshot_model p=%0d c=%0d tick=%b/%b sq=%b/%b done=%b/%b", pass, c, tick, m_tick, sq, m_sq, done, m_done);
        end
        checks++;
        if (tick[2] !== (c == 6) || done[2] !== (c >= 6)) begin
          errors++;
          $display("FAIL oneshot_flag p=%0d c=%0d tick=%b done=%b want %b %b", pass, c, tick[2], done[2], (c == 6), (c >= 6));
        end
      end
      enable = '0;
      @(negedge clock);
      checks++;
      if (done[2] !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_rearm got done=%b want 0", done[2]);
      end
    end
    mode = '0;
  endtask

  task automatic test_sync_clear();
    int unsigned n[3] = '{3, 5, 7};
    for (int j = 0; j < 3; j++) div_in[j*CW +: CW] = CW'(n[j]);
    div_load = 4'b0111;
    @(negedge clock);
    div_load = '0;
    enable = 4'b0111;
    repeat (11) @(negedge clock);
    sync_clear = 1'b1;
    @(negedge clock);
    sync_clear = 1'b0;
    checks++;
    if (sq !== 4'b0000 || tick !== 4'b0000) begin
      errors++;
      $display("FAIL clear_outputs sq=%b tick=%b want 0000 0000", sq, tick);
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      checks++;
      if (tick !== m_tick || sq !== m_sq || done !== m_done) begin
        errors++;
        $display("FAIL clear_model c=%0d tick=%b/%b sq=%b/%b done=%b/%b", c, tick, m_tick, sq, m_sq, done, m_done);
      end
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (tick[j] !== (c % n[j] == 0)) begin
          errors++;
          $display("FAIL clear_tick ch=%0d c=%0d got %b want %b", j, c, tick[j], (c % n[j] == 0));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int hit = 0;
    reset = 1'b1;
    #1;
    checks++;
    if ({tick, sq, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid tick=%b sq=%b done=%b want all 0", tick, sq, done);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 12 && hit == 0; c++) begin
      @(negedge clock);
      if (m_tick != '0) begin
        hit = 1;
        reset = 1'b1;
        #1;
        checks++;
        if ({tick, sq, done} !== '0) begin
          errors++;
          $display("FAIL reset_tc tick=%b sq=%b done=%b want all 0", tick, sq, done);
        end
      end
    end
    checks++;
    if (hit == 0) begin
      errors++;
      $display("FAIL reset_tc_timeout got no tick want one within 12 cycles");
    end
    @(negedge clock);
    reset = 1'b0;
    enable = '0;
    div_in[0*CW +: CW] = CW'(1);
    div_in[3*CW +: CW] = CW'(0);
    div_load = 4'b1001;
    @(negedge clock);
    div_load = '0;
    enable = 4'b1001;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      checks++;
      if (tick !== m_tick || sq !== m_sq || done !== m_done) begin
        errors++;
        $display("FAIL n01_model c=%0d tick=%b/%b sq=%b/%b done=%b/%b", c, tick, m_tick, sq, m_sq, done, m_done);
      end
      checks++;
      if (tick !== 4'b1001 || sq[0] !== c[0] || sq[3] !== c[0]) begin
        errors++;
        $display("FAIL n01_tick c=%0d tick=%b sq=%b want tick 1001 sq bits %b", c, tick, sq, c[0]);
      end
    end
    enable = '0;
    @(negedge clock);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      checks++;
      if (tick !== m_tick || sq !== m_sq || done !== m_done) begin
        errors++;
        $display("FAIL random c=%0d tick=%b/%b sq=%b/%b done=%b/%b", c, tick, m_tick, sq, m_sq, done, m_done);
      end
      for (int i = 0; i < CH; i++) begin
        enable[i]   = ($urandom_range(0, 24) != 0);
        div_load[i] = ($urandom_range(0, 9) == 0);
        div_in[i*CW +: CW] = CW'($urandom_range(0, 9));
        if ($urandom_range(0, 15) == 0) mode[i] = ~mode[i];
      end
      sync_clear = ($urandom_range(0, 39) == 0);
    end
    enable = '0; div_load = '0; sync_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_div_update();
    test_bypass();
    test_oneshot();
    test_sync_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
